// File: rtl/rv_mem_pkg.sv
// Shared types and widths for the program/data memory port arbiter.
//   mem_owner_t : which requester owns the outstanding transaction
//   arb_state_t : arbiter FSM state (idle / one transaction outstanding)
//   WORD_W      : data word width
//   STRB_W      : byte-enable width
package rv_mem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } mem_owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the fetch port.
// Counts consecutive cycles in which fetch is requesting but loses to data.
// Once it reaches STARVE_LIMIT, force_i tells the arbiter to grant fetch.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_req      : fetch request pending
//   i_gnt      : fetch granted this cycle
//   d_gnt      : data granted this cycle
//   force_i    : counter has reached STARVE_LIMIT
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic force_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (i_gnt || !i_req) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_i = (starve_cnt == LIMIT);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one word-addressed memory port between instruction fetch (I) and
// load/store (D). D has fixed priority; fetch is forced after STARVE_LIMIT
// consecutive lost cycles. One transaction outstanding at most; a new one
// may issue in the same cycle the previous response returns.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | no transaction outstanding
// ST_WAIT  | one transaction outstanding, owner_q owns it
//
// Ports:
//   clk, rst_n                              clock, async active-low reset
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata  fetch port
//   d_req/d_we/d_addr/d_wdata/d_wstrb
//            -> d_gnt/d_rvalid/d_rdata      load/store port
//   mem_en/we/addr/wdata/wstrb, mem_ready,
//   mem_rvalid/mem_rdata                    memory side
module imem_dmem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [WORD_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    input  logic [STRB_W-1:0] d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata
);

    arb_state_t state_q, state_d;
    mem_owner_t owner_q, owner_d;
    logic       store_q, store_d;

    logic can_issue;
    logic sel_d;
    logic sel_i;
    logic force_i;
    logic accept;
    logic resp_valid;

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_gnt   (i_gnt),
        .d_gnt   (d_gnt),
        .force_i (force_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        store_d    = store_q;

        can_issue  = (state_q == ST_IDLE) || (state_q == ST_WAIT && mem_rvalid);
        sel_d      = d_req && !(i_req && force_i);
        sel_i      = i_req && !sel_d;

        // rst_n gating keeps every output low while reset is held, even
        // though the request inputs may still be active.
        mem_en     = rst_n && can_issue && (i_req || d_req);
        accept     = mem_en && mem_ready;
        i_gnt      = accept && sel_i;
        d_gnt      = accept && sel_d;

        mem_we     = mem_en && sel_d && d_we;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        if (mem_en) begin
            if (sel_d) begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_wstrb = d_wstrb;
            end else begin
                mem_addr  = i_addr;
            end
        end

        // A response outside WAIT (stray or after reset) is dropped here.
        resp_valid = (state_q == ST_WAIT) && mem_rvalid;
        i_rvalid   = resp_valid && (owner_q == OWN_I);
        d_rvalid   = resp_valid && (owner_q == OWN_D);
        i_rdata    = i_rvalid ? mem_rdata : '0;
        d_rdata    = (d_rvalid && !store_q) ? mem_rdata : '0;

        if (can_issue) begin
            if (accept) begin
                state_d = ST_WAIT;
                owner_d = sel_d ? OWN_D : OWN_I;
                store_d = sel_d && d_we;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    imem_dmem_arbiter #(
        .ADDR_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change #1 after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".i_gnt"},     32'(i_gnt),     32'd0);
        chk({tag, ".i_rvalid"},  32'(i_rvalid),  32'd0);
        chk({tag, ".i_rdata"},   i_rdata,        32'd0);
        chk({tag, ".d_gnt"},     32'(d_gnt),     32'd0);
        chk({tag, ".d_rvalid"},  32'(d_rvalid),  32'd0);
        chk({tag, ".d_rdata"},   d_rdata,        32'd0);
        chk({tag, ".mem_en"},    32'(mem_en),    32'd0);
        chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
        chk({tag, ".mem_addr"},  mem_addr,       32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    endtask

    logic [9:0] exp_d_order;

    initial begin
        rst_n      = 1'b0;
        i_req      = 1'b0;
        i_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_wstrb    = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        #1;
        chk_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset_idle");

        // 1: single fetch, 1-cycle memory
        i_req  = 1'b1;
        i_addr = 32'h100;
        #1;
        chk("t1.i_gnt",    32'(i_gnt),  32'd1);
        chk("t1.d_gnt",    32'(d_gnt),  32'd0);
        chk("t1.mem_en",   32'(mem_en), 32'd1);
        chk("t1.mem_addr", mem_addr,    32'h100);
        chk("t1.mem_we",   32'(mem_we), 32'd0);
        tick();
        i_req      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        #1;
        chk("t1.i_rvalid", 32'(i_rvalid), 32'd1);
        chk("t1.i_rdata",  i_rdata,       32'hDEADBEEF);
        chk("t1.d_rvalid", 32'(d_rvalid), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("t1.idle_i_rvalid", 32'(i_rvalid), 32'd0);

        // 2: both held, starvation guard: D,D,D,D,I,D,D,D,D,I (bit k = D wins)
        exp_d_order = 10'b01111_01111;
        i_req  = 1'b1;
        i_addr = 32'h300;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        for (int k = 0; k < 10; k++) begin
            mem_rvalid = (k > 0);
            mem_rdata  = 32'hA000_0000 + 32'(k);
            #1;
            chk($sformatf("t2.d_gnt[%0d]", k), 32'(d_gnt), 32'(exp_d_order[k]));
            chk($sformatf("t2.i_gnt[%0d]", k), 32'(i_gnt), 32'(!exp_d_order[k]));
            chk($sformatf("t2.mem_addr[%0d]", k), mem_addr,
                exp_d_order[k] ? 32'h200 : 32'h300);
            if (k > 0) begin
                chk($sformatf("t2.d_rvalid[%0d]", k), 32'(d_rvalid), 32'(exp_d_order[k-1]));
                chk($sformatf("t2.i_rvalid[%0d]", k), 32'(i_rvalid), 32'(!exp_d_order[k-1]));
                chk($sformatf("t2.rdata[%0d]", k),
                    exp_d_order[k-1] ? d_rdata : i_rdata, 32'hA000_0000 + 32'(k));
            end
            tick();
        end
        i_req      = 1'b0;
        d_req      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA000_000A;
        #1;
        chk("t2.last_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("t2.last_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("t2.last_i_rdata",  i_rdata,       32'hA000_000A);
        tick();
        mem_rvalid = 1'b0;

        // 3: store, ack returns zero data
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'h12345678;
        d_wstrb = 4'b0011;
        #1;
        chk("t3.d_gnt",     32'(d_gnt),     32'd1);
        chk("t3.mem_we",    32'(mem_we),    32'd1);
        chk("t3.mem_wstrb", 32'(mem_wstrb), 32'b0011);
        chk("t3.mem_wdata", mem_wdata,      32'h12345678);
        chk("t3.mem_addr",  mem_addr,       32'h40);
        tick();
        d_req      = 1'b0;
        d_we       = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hAAAA5555;
        #1;
        chk("t3.d_rvalid", 32'(d_rvalid), 32'd1);
        chk("t3.d_rdata",  d_rdata,       32'd0);
        chk("t3.i_rvalid", 32'(i_rvalid), 32'd0);
        tick();
        mem_rvalid = 1'b0;

        // 4: memory back-pressure
        mem_ready = 1'b0;
        i_req     = 1'b1;
        i_addr    = 32'h500;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4.i_gnt[%0d]", k),    32'(i_gnt),  32'd0);
            chk($sformatf("t4.mem_en[%0d]", k),   32'(mem_en), 32'd1);
            chk($sformatf("t4.mem_addr[%0d]", k), mem_addr,    32'h500);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("t4.i_gnt_ready", 32'(i_gnt), 32'd1);
        tick();
        #1;
        chk("t4.i_gnt_once", 32'(i_gnt),  32'd0);
        chk("t4.mem_en_wait", 32'(mem_en), 32'd0);
        i_req      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_5000;
        #1;
        chk("t4.i_rvalid", 32'(i_rvalid), 32'd1);
        tick();
        mem_rvalid = 1'b0;

        // 5: reset while a transaction is outstanding
        i_req  = 1'b1;
        i_addr = 32'h700;
        #1;
        chk("t5.i_gnt", 32'(i_gnt), 32'd1);
        tick();
        rst_n      = 1'b0;
        d_req      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        #1;
        chk_all_zero("t5.in_reset");
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("t5.late_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("t5.late_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("t5.late_i_rdata",  i_rdata,       32'd0);
        tick();
        mem_rvalid = 1'b0;

        // 6: 3-cycle memory, re-issue on the response cycle
        i_req  = 1'b1;
        i_addr = 32'h600;
        #1;
        chk("t6.i_gnt0", 32'(i_gnt), 32'd1);
        tick();
        i_addr = 32'h604;
        for (int k = 1; k < 3; k++) begin
            #1;
            chk($sformatf("t6.mem_en_wait[%0d]", k), 32'(mem_en), 32'd0);
            chk($sformatf("t6.i_gnt_wait[%0d]", k),  32'(i_gnt),  32'd0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADF00D;
        #1;
        chk("t6.i_rvalid",  32'(i_rvalid), 32'd1);
        chk("t6.i_rdata",   i_rdata,       32'h0BADF00D);
        chk("t6.i_gnt_b2b", 32'(i_gnt),    32'd1);
        chk("t6.mem_addr",  mem_addr,      32'h604);
        tick();
        i_req      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0604;
        #1;
        chk("t6.second_i_rvalid", 32'(i_rvalid), 32'd1);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk_all_zero("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
